scaler_h_step_ctrl: RTL and testbench

Configuration sequencer for the horizontal cubic scaler (`scaler_h`). It accepts an input-width/output-width pair from the host side and computes the unsigned fixed-point `scale_step` with a rounded serial divider. The new step is applied only at the first active pixel of a frame on the scaler's input stream, so a frame is never scaled with mixed steps. The block sits between the register interface and `scaler_h.scale_step`, and monitors the same `de_i/hs_i/vs_i` that feed the scaler.

---
 rtl/scaler_h_step_ctrl_if.sv | 28 ++
 rtl/scaler_h_step_ctrl.sv | 109 ++++++++++
 tb/tb_scaler_h_step_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_h_step_ctrl_if.sv
// Host configuration, scaler sync monitoring and step output for scaler_h_step_ctrl.
interface scaler_h_step_ctrl_if #(
    parameter int unsigned WIDTH_BITS = 12
);
    logic                  cfg_wr;
    logic [WIDTH_BITS-1:0] cfg_in_w;
    logic [WIDTH_BITS-1:0] cfg_out_w;
    logic                  cfg_busy;
    logic                  cfg_pend;
    logic                  cfg_err;
    logic                  de_i;
    logic                  hs_i;
    logic                  vs_i;
    logic [15:0]           scale_step;
    logic                  step_update;

    // Host / stream side
    modport master (
        output cfg_wr, cfg_in_w, cfg_out_w, de_i, hs_i, vs_i,
        input  cfg_busy, cfg_pend, cfg_err, scale_step, step_update
    );

    // Controller side
    modport slave (
        input  cfg_wr, cfg_in_w, cfg_out_w, de_i, hs_i, vs_i,
        output cfg_busy, cfg_pend, cfg_err, scale_step, step_update
    );
endinterface

// File: rtl/scaler_h_step_ctrl.sv
// Computes scale_step = round(in_w * PIXEL_STEP / out_w) with a serial restoring
// divider and applies it only at the first active pixel of a frame.
module scaler_h_step_ctrl #(
    parameter int unsigned PIXEL_STEP = 4096,
    parameter int unsigned WIDTH_BITS = 12
) (
    input logic                clk,
    input logic                rst_n,
    scaler_h_step_ctrl_if.slave bus
);
    localparam int unsigned FRAC_BITS = $clog2(PIXEL_STEP);
    localparam int unsigned N         = WIDTH_BITS + FRAC_BITS;
    localparam int unsigned CNT_W     = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StDiv, StPend} state_t;

    state_t                state;
    logic [N:0]            rem;       // one bit of headroom over the quotient width
    logic [N-1:0]          quot;      // numerator shifts out MSB-first, quotient shifts in
    logic [WIDTH_BITS-1:0] out_w;
    logic [CNT_W-1:0]      cnt;
    logic [15:0]           pend_step;

    logic [N-1:0]          nm_load;
    logic [N+1:0]          rem_shift;
    logic [N+1:0]          den_ext;
    logic                  fits;
    logic [N:0]            rem_next;
    logic [N-1:0]          quot_next;
    logic                  sat;
    logic [15:0]           step_res;
    logic                  zero_w;
    logic                  last;
    logic                  frame_start;

    // Divider datapath and request decode
    always_comb begin
        zero_w      = (bus.cfg_in_w == '0) || (bus.cfg_out_w == '0);
        // Adding out_w/2 before flooring rounds the quotient to nearest
        nm_load     = (N'(bus.cfg_in_w) << FRAC_BITS) + N'(bus.cfg_out_w >> 1);
        rem_shift   = {rem, quot[N-1]};
        den_ext     = (N + 2)'(out_w);
        fits        = rem_shift >= den_ext;
        rem_next    = fits ? (N + 1)'(rem_shift - den_ext) : (N + 1)'(rem_shift);
        quot_next   = {quot[N-2:0], fits};
        sat         = (quot_next >> 16) != '0;
        step_res    = sat ? 16'hFFFF : quot_next[15:0];
        last        = cnt == CNT_W'(N - 1);
        frame_start = bus.de_i && bus.vs_i;
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            rem             <= '0;
            quot            <= '0;
            out_w           <= '0;
            cnt             <= '0;
            pend_step       <= '0;
            bus.cfg_busy    <= 1'b0;
            bus.cfg_pend    <= 1'b0;
            bus.cfg_err     <= 1'b0;
            bus.scale_step  <= 16'(PIXEL_STEP);
            bus.step_update <= 1'b0;
        end else begin
            bus.step_update <= 1'b0;
            unique case (state)
                StIdle, StPend: begin
                    if (bus.cfg_wr) begin
                        // A write in PEND drops the waiting step, even on a frame start
                        out_w        <= bus.cfg_out_w;
                        bus.cfg_err  <= zero_w;
                        bus.cfg_pend <= 1'b0;
                        if (zero_w) begin
                            state <= StIdle;
                        end else begin
                            rem          <= '0;
                            quot         <= nm_load;
                            cnt          <= '0;
                            bus.cfg_busy <= 1'b1;
                            state        <= StDiv;
                        end
                    end else if (state == StPend && frame_start) begin
                        bus.scale_step  <= pend_step;
                        bus.step_update <= 1'b1;
                        bus.cfg_pend    <= 1'b0;
                        state           <= StIdle;
                    end
                end
                StDiv: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        pend_step    <= step_res;
                        bus.cfg_busy <= 1'b0;
                        bus.cfg_pend <= 1'b1;
                        if (sat) begin
                            bus.cfg_err <= 1'b1;
                        end
                        state <= StPend;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_scaler_h_step_ctrl.sv
// Scoreboard bench for scaler_h_step_ctrl: stimulus pushes expected steps, a
// monitor pops them whenever step_update fires.
module tb_scaler_h_step_ctrl;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scaler_h_step_ctrl_if #(.WIDTH_BITS(W)) bus ();

    scaler_h_step_ctrl #(
        .PIXEL_STEP(4096),
        .WIDTH_BITS(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];
    int cur_step = 4096;
    int pend_step = 0;

    // Nearest-integer of in*4096/out, halves rounding up, clamped to 16 bits
    function automatic longint ref_raw(int in_w, int out_w);
        return (2 * longint'(in_w) * 4096 + longint'(out_w)) / (2 * longint'(out_w));
    endfunction

    function automatic int ref_step(int in_w, int out_w);
        longint r = ref_raw(in_w, out_w);
        return (r > 65535) ? 65535 : int'(r);
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every step_update must match the oldest expected step
    always @(negedge clk) begin
        if (rst_n && bus.step_update) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_update: got step %0d, expected no update", bus.scale_step);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("applied_step", bus.scale_step, e);
                cur_step = e;
            end
        end
    end

    task automatic write_cfg(int in_w, int out_w, bit with_frame);
        @(posedge clk);
        #1;
        bus.cfg_wr    = 1'b1;
        bus.cfg_in_w  = W'(in_w);
        bus.cfg_out_w = W'(out_w);
        bus.de_i      = with_frame;
        bus.vs_i      = with_frame;
        bus.hs_i      = with_frame;
        @(posedge clk);
        #1;
        bus.cfg_wr = 1'b0;
        bus.de_i   = 1'b0;
        bus.vs_i   = 1'b0;
        bus.hs_i   = 1'b0;
    endtask

    task automatic wait_busy_low(output int cycles);
        cycles = 0;
        while (bus.cfg_busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Full configuration pass; leaves the model's pending step set on success
    task automatic run_config(int in_w, int out_w, output bit ok);
        int cyc;
        ok = 1'b0;
        write_cfg(in_w, out_w, 1'b0);
        if (in_w == 0 || out_w == 0) begin
            check("zero_err", bus.cfg_err, 1);
            check("zero_no_busy", bus.cfg_busy, 0);
            return;
        end
        check("busy_start", bus.cfg_busy, 1);
        check("err_cleared", bus.cfg_err, 0);
        wait_busy_low(cyc);
        check("div_cycles", cyc, 24);
        check("pend_set", bus.cfg_pend, 1);
        check("sat_err", bus.cfg_err, (ref_raw(in_w, out_w) > 65535) ? 1 : 0);
        pend_step = ref_step(in_w, out_w);
        ok = 1'b1;
    endtask

    task automatic apply_frame();
        @(posedge clk);
        #1;
        bus.de_i = 1'b1;
        bus.vs_i = 1'b1;
        bus.hs_i = 1'b1;
        exp_q.push_back(pend_step);
        @(posedge clk);
        #1;
        bus.de_i = 1'b0;
        bus.vs_i = 1'b0;
        bus.hs_i = 1'b0;
        check("pend_cleared", bus.cfg_pend, 0);
        check("update_pulse", bus.step_update, 1);
        @(posedge clk);
        #1;
        check("update_single", bus.step_update, 0);
    endtask

    // Active lines without vs_i must not apply the pending step
    task automatic lines_without_vs(int n_lines);
        for (int l = 0; l < n_lines; l++) begin
            @(posedge clk);
            #1;
            bus.hs_i = 1'b1;
            bus.de_i = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            bus.hs_i = 1'b0;
            bus.de_i = 1'b0;
            repeat (2) @(posedge clk);
        end
        #1;
        check("gated_step", bus.scale_step, cur_step);
        check("gated_pend", bus.cfg_pend, 1);
    endtask

    initial begin
        bit ok;
        int cyc;
        bus.cfg_wr    = 1'b0;
        bus.cfg_in_w  = '0;
        bus.cfg_out_w = '0;
        bus.de_i      = 1'b0;
        bus.hs_i      = 1'b0;
        bus.vs_i      = 1'b0;

        // Reset with random inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.cfg_wr    = 1'($urandom);
            bus.cfg_in_w  = W'($urandom);
            bus.cfg_out_w = W'($urandom);
            bus.de_i      = 1'($urandom);
            bus.vs_i      = 1'($urandom);
            bus.hs_i      = 1'($urandom);
        end
        @(negedge clk);
        bus.cfg_wr = 1'b0;
        bus.de_i   = 1'b0;
        bus.vs_i   = 1'b0;
        bus.hs_i   = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;
        check("rst_step", bus.scale_step, 4096);
        check("rst_busy", bus.cfg_busy, 0);
        check("rst_pend", bus.cfg_pend, 0);
        check("rst_err", bus.cfg_err, 0);
        check("rst_update", bus.step_update, 0);

        // Downscale, with frame gating before the vs pixel
        run_config(1920, 1280, ok);
        check("ref_6144", pend_step, 6144);
        lines_without_vs(3);
        apply_frame();

        // Upscale rounding
        run_config(1280, 1920, ok);
        apply_frame();
        run_config(1000, 3000, ok);
        apply_frame();

        // Saturation, then zero width, then recovery
        run_config(4095, 1, ok);
        apply_frame();
        check("sat_err_sticky", bus.cfg_err, 1);
        run_config(100, 0, ok);
        repeat (5) @(posedge clk);
        #1;
        check("zero_idle_busy", bus.cfg_busy, 0);
        check("zero_idle_pend", bus.cfg_pend, 0);
        check("zero_keeps_step", bus.scale_step, 65535);
        run_config(1000, 3000, ok);
        apply_frame();

        // Write during DIV is ignored
        write_cfg(1920, 1280, 1'b0);
        @(posedge clk);
        #1;
        bus.cfg_wr    = 1'b1;
        bus.cfg_in_w  = W'(100);
        bus.cfg_out_w = W'(50);
        @(posedge clk);
        #1;
        bus.cfg_wr = 1'b0;
        wait_busy_low(cyc);
        check("div_ignore_cycles", cyc, 22);
        check("div_ignore_pend", bus.cfg_pend, 1);
        pend_step = 6144;
        apply_frame();

        // Write colliding with frame start in PEND wins
        run_config(1280, 1920, ok);
        write_cfg(640, 1280, 1'b1);
        check("collide_busy", bus.cfg_busy, 1);
        check("collide_pend", bus.cfg_pend, 0);
        check("collide_step", bus.scale_step, cur_step);
        wait_busy_low(cyc);
        check("collide_cycles", cyc, 24);
        pend_step = 2048;
        apply_frame();

        // Zero-width write in PEND returns to IDLE with error
        run_config(500, 600, ok);
        write_cfg(0, 5, 1'b0);
        check("pend_zero_err", bus.cfg_err, 1);
        check("pend_zero_pend", bus.cfg_pend, 0);
        check("pend_zero_busy", bus.cfg_busy, 0);

        // Randomized configurations
        for (int i = 0; i < 30; i++) begin
            int in_w;
            int out_w;
            in_w  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4095));
            out_w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4095));
            run_config(in_w, out_w, ok);
            if (ok) begin
                if ($urandom_range(0, 2) == 0) lines_without_vs(1);
                apply_frame();
            end
        end

        // Reset mid-DIV abandons the computation
        write_cfg(800, 400, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_step", bus.scale_step, 4096);
        check("mid_rst_busy", bus.cfg_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_step = 4096;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_pend", bus.cfg_pend, 0);
        check("post_rst_step", bus.scale_step, 4096);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
